ines_loader: RTL and testbench

- Upstream feeder for rom_master.
- Accepts an iNES image as a byte stream (valid/ready) from a host link (UART/SD bridge) and parses the 16-byte header.
- Writes PRG bytes into rom_master's PRG store and CHR bytes into its CHR store.
- Publishes cartridge config: PRG-16K mirror flag and nametable mirroring.
- Holds the system (CPU/PPU) until the image is fully loaded.

---
 rtl/ines_loader_if.sv | 34 +++
 rtl/ines_loader.sv | 217 +++++++++++++++++++++
 tb/tb_ines_loader.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ines_loader_if.sv
// ines_loader_if: host byte stream into the loader, PRG/CHR store write buses and the
// cartridge configuration published to rom_master and the system reset logic.
interface ines_loader_if #(
  parameter int PRG_AW = 15,
  parameter int CHR_AW = 13
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              prg_we;
  logic [PRG_AW-1:0] prg_wa;
  logic [7:0]        prg_wd;
  logic              chr_we;
  logic [CHR_AW-1:0] chr_wa;
  logic [7:0]        chr_wd;
  logic              prg_16k;
  logic              mirror_v;
  logic              done;
  logic              err;
  logic [2:0]        err_code;
  logic              sys_hold;

  modport master (
    output in_data, in_valid,
    input  in_ready, prg_we, prg_wa, prg_wd, chr_we, chr_wa, chr_wd,
    input  prg_16k, mirror_v, done, err, err_code, sys_hold
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, prg_we, prg_wa, prg_wd, chr_we, chr_wa, chr_wd,
    output prg_16k, mirror_v, done, err, err_code, sys_hold
  );
endinterface

// File: rtl/ines_loader.sv
// ines_loader: parses an iNES byte stream, writes PRG/CHR bytes into rom_master's stores
// and holds the system until loaded. Define INES_TRAINER_SKIP_EN to skip 512-byte trainers.
module ines_loader #(
  parameter int PRG_AW = 15,
  parameter int CHR_AW = 13
) (
  input  logic         clk,
  input  logic         rst,
  ines_loader_if.slave bus
);
  localparam int         CW      = ((PRG_AW > CHR_AW) ? PRG_AW : CHR_AW) + 1;
  localparam logic [8:0] PRG_MAX = 9'(1 << (PRG_AW - 14));
  localparam logic [8:0] CHR_MAX = 9'(1 << (CHR_AW - 13));

  typedef enum logic [2:0] {
    S_HDR     = 3'd0,
`ifdef INES_TRAINER_SKIP_EN
    S_TRAINER = 3'd1,
`endif
    S_PRG     = 3'd2,
    S_CHR     = 3'd3,
    S_DONE    = 3'd4,
    S_ERR     = 3'd5
  } state_t;

  state_t            state_r;
  logic [CW-1:0]     cnt_r;
  logic [7:0]        prg_banks_r;
  logic [7:0]        chr_banks_r;
  logic [3:0]        mapper_lo_r;
  logic [3:0]        mapper_hi_r;
  logic              trainer_r;
  logic              mirror_lat_r;
  logic              in_ready_r;
  logic              prg_we_r;
  logic [PRG_AW-1:0] prg_wa_r;
  logic [7:0]        prg_wd_r;
  logic              chr_we_r;
  logic [CHR_AW-1:0] chr_wa_r;
  logic [7:0]        chr_wd_r;
  logic              prg_16k_r;
  logic              mirror_v_r;
  logic              done_r;
  logic              err_r;
  logic [2:0]        err_code_r;
  logic              sys_hold_r;

  logic              accept_s;
  logic [CW-1:0]     prg_last_s;
  logic [CW-1:0]     chr_last_s;
  logic [2:0]        hdr_code_s;

  function automatic logic [7:0] magic_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    magic_byte = 8'h4E;
      2'd1:    magic_byte = 8'h45;
      2'd2:    magic_byte = 8'h53;
      default: magic_byte = 8'h1A;
    endcase
  endfunction

  // Handshake, section end addresses and header verdict (first failing check wins).
  always_comb begin
    accept_s   = bus.in_valid & in_ready_r;
    prg_last_s = (CW'(prg_banks_r) << 14) - CW'(1);
    chr_last_s = (CW'(chr_banks_r) << 13) - CW'(1);
    if (prg_banks_r == 8'd0 || {1'b0, prg_banks_r} > PRG_MAX) begin
      hdr_code_s = 3'd2;
    end else if (chr_banks_r == 8'd0 || {1'b0, chr_banks_r} > CHR_MAX) begin
      hdr_code_s = 3'd3;
    end else if ({mapper_hi_r, mapper_lo_r} != 8'd0) begin
      hdr_code_s = 3'd4;
`ifndef INES_TRAINER_SKIP_EN
    end else if (trainer_r) begin
      hdr_code_s = 3'd5;
`endif
    end else begin
      hdr_code_s = 3'd0;
    end
  end

  // Load sequencer: header parse, optional trainer skip, PRG then CHR write-out.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_HDR;
      cnt_r        <= '0;
      prg_banks_r  <= 8'd0;
      chr_banks_r  <= 8'd0;
      mapper_lo_r  <= 4'd0;
      mapper_hi_r  <= 4'd0;
      trainer_r    <= 1'b0;
      mirror_lat_r <= 1'b0;
      in_ready_r   <= 1'b0;
      prg_we_r     <= 1'b0;
      prg_wa_r     <= '0;
      prg_wd_r     <= 8'd0;
      chr_we_r     <= 1'b0;
      chr_wa_r     <= '0;
      chr_wd_r     <= 8'd0;
      prg_16k_r    <= 1'b0;
      mirror_v_r   <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
      err_code_r   <= 3'd0;
      sys_hold_r   <= 1'b1;
    end else begin
      prg_we_r <= 1'b0;
      chr_we_r <= 1'b0;
      case (state_r)
        S_HDR: begin
          in_ready_r <= 1'b1;
          if (accept_s) begin
            cnt_r <= cnt_r + CW'(1);
            case (cnt_r[3:0])
              4'd0, 4'd1, 4'd2, 4'd3: begin
                if (bus.in_data != magic_byte(cnt_r[1:0])) begin
                  state_r    <= S_ERR;
                  in_ready_r <= 1'b0;
                  err_r      <= 1'b1;
                  err_code_r <= 3'd1;
                end
              end
              4'd4: prg_banks_r <= bus.in_data;
              4'd5: chr_banks_r <= bus.in_data;
              4'd6: begin
                mirror_lat_r <= bus.in_data[0];
                trainer_r    <= bus.in_data[2];
                mapper_lo_r  <= bus.in_data[7:4];
              end
              4'd7: mapper_hi_r <= bus.in_data[7:4];
              4'd15: begin
                if (hdr_code_s != 3'd0) begin
                  state_r    <= S_ERR;
                  in_ready_r <= 1'b0;
                  err_r      <= 1'b1;
                  err_code_r <= hdr_code_s;
                end else begin
                  cnt_r      <= '0;
                  prg_16k_r  <= (prg_banks_r == 8'd1);
                  mirror_v_r <= mirror_lat_r;
`ifdef INES_TRAINER_SKIP_EN
                  state_r    <= trainer_r ? S_TRAINER : S_PRG;
`else
                  state_r    <= S_PRG;
`endif
                end
              end
              default: ;
            endcase
          end
        end
`ifdef INES_TRAINER_SKIP_EN
        S_TRAINER: begin
          if (accept_s) begin
            if (cnt_r == CW'(511)) begin
              cnt_r   <= '0;
              state_r <= S_PRG;
            end else begin
              cnt_r <= cnt_r + CW'(1);
            end
          end
        end
`endif
        S_PRG: begin
          if (accept_s) begin
            prg_we_r <= 1'b1;
            prg_wa_r <= cnt_r[PRG_AW-1:0];
            prg_wd_r <= bus.in_data;
            if (cnt_r == prg_last_s) begin
              cnt_r   <= '0;
              state_r <= S_CHR;
            end else begin
              cnt_r <= cnt_r + CW'(1);
            end
          end
        end
        S_CHR: begin
          if (accept_s) begin
            chr_we_r <= 1'b1;
            chr_wa_r <= cnt_r[CHR_AW-1:0];
            chr_wd_r <= bus.in_data;
            if (cnt_r == chr_last_s) begin
              // done and sys_hold release line up with the final CHR strobe
              state_r    <= S_DONE;
              in_ready_r <= 1'b0;
              done_r     <= 1'b1;
              sys_hold_r <= 1'b0;
            end else begin
              cnt_r <= cnt_r + CW'(1);
            end
          end
        end
        S_DONE: in_ready_r <= 1'b0;
        S_ERR:  in_ready_r <= 1'b0;
        default: begin
          state_r    <= S_ERR;
          in_ready_r <= 1'b0;
          err_r      <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready = in_ready_r;
  assign bus.prg_we   = prg_we_r;
  assign bus.prg_wa   = prg_wa_r;
  assign bus.prg_wd   = prg_wd_r;
  assign bus.chr_we   = chr_we_r;
  assign bus.chr_wa   = chr_wa_r;
  assign bus.chr_wd   = chr_wd_r;
  assign bus.prg_16k  = prg_16k_r;
  assign bus.mirror_v = mirror_v_r;
  assign bus.done     = done_r;
  assign bus.err      = err_r;
  assign bus.err_code = err_code_r;
  assign bus.sys_hold = sys_hold_r;
endmodule

// File: tb/tb_ines_loader.sv
// tb_ines_loader: randomized iNES images driven into ines_loader, checked against a
// file-layout reference model (expected error code, consumed length, PRG/CHR write image).
module tb_ines_loader;
  localparam int PRG_AW  = 15;
  localparam int CHR_AW  = 13;
  localparam int IMG_MAX = 49152;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ines_loader_if #(.PRG_AW(PRG_AW), .CHR_AW(CHR_AW)) bus_if ();
  ines_loader #(.PRG_AW(PRG_AW), .CHR_AW(CHR_AW)) dut (.clk(clk), .rst(rst), .bus(bus_if));

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [7:0]  img [IMG_MAX];
  logic [7:0]  magic_c [4] = '{8'h4E, 8'h45, 8'h53, 8'h1A};
  int          cyc = 0;
  int          acc_cyc, done_cyc, err_cyc, chr_last_cyc;
  bit          done_seen, err_seen;
  logic [31:0] prg_a[$], prg_d[$], chr_a[$], chr_d[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // cycle counter: number of rising edges so far
  always @(posedge clk) cyc <= cyc + 1;

  // write-bus and status monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (bus_if.prg_we) begin
      prg_a.push_back(32'(bus_if.prg_wa));
      prg_d.push_back(32'(bus_if.prg_wd));
    end
    if (bus_if.chr_we) begin
      chr_a.push_back(32'(bus_if.chr_wa));
      chr_d.push_back(32'(bus_if.chr_wd));
      chr_last_cyc <= cyc;
    end
    if (bus_if.done && !done_seen) begin
      done_seen <= 1'b1;
      done_cyc  <= cyc;
    end
    if (bus_if.err && !err_seen) begin
      err_seen <= 1'b1;
      err_cyc  <= cyc;
    end
  end

  // reference model: outcome of an image purely from its header bytes
  function automatic int model_code();
    int prg_max, chr_max;
    logic [7:0] mapper;
    prg_max = 1 << (PRG_AW - 14);
    chr_max = 1 << (CHR_AW - 13);
    for (int i = 0; i < 4; i++) if (img[i] != magic_c[i]) return 1;
    if (img[4] == 8'd0 || int'(img[4]) > prg_max) return 2;
    if (img[5] == 8'd0 || int'(img[5]) > chr_max) return 3;
    mapper = {img[7][7:4], img[6][7:4]};
    if (mapper != 8'd0) return 4;
`ifndef INES_TRAINER_SKIP_EN
    if (img[6][2]) return 5;
`endif
    return 0;
  endfunction

  function automatic int model_consumed(input int code);
    if (code == 1) begin
      for (int i = 0; i < 4; i++) if (img[i] != magic_c[i]) return i + 1;
    end
    if (code != 0) return 16;
    return 16 + (img[6][2] ? 512 : 0) + int'(img[4]) * 16384 + int'(img[5]) * 8192;
  endfunction

  task automatic build_img(input logic [7:0] h4, input logic [7:0] h5, input logic [7:0] h6,
                           input logic [7:0] h7, input int bad_idx, input logic [7:0] bad_val);
    for (int i = 0; i < IMG_MAX; i++) img[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) img[i] = magic_c[i];
    if (bad_idx >= 0) img[bad_idx] = bad_val;
    img[4] = h4;
    img[5] = h5;
    img[6] = h6;
    img[7] = h7;
    img[16 + 32'h3FFC] = 8'h07;
  endtask

  task automatic send(input int n, input bit throttle, output int sent);
    int idle, t;
    sent = 0;
    idle = 0;
    t    = 0;
    while (sent < n && idle < 16) begin
      @(negedge clk);
      t++;
      if (throttle && t[0]) begin
        bus_if.in_valid = 1'b0;
      end else begin
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = img[sent];
      end
      if (bus_if.in_valid && bus_if.in_ready) begin
        sent++;
        acc_cyc = cyc + 1;
        idle    = 0;
      end else if (bus_if.in_valid) begin
        idle++;
      end
    end
    @(negedge clk);
    bus_if.in_valid = 1'b0;
  endtask

  task automatic do_reset(input bit check_vals);
    @(negedge clk);
    rst = 1'b1;
    bus_if.in_valid = 1'b0;
    @(negedge clk);
    if (check_vals) begin
      check_eq("rst_flags", {23'd0, bus_if.in_ready, bus_if.prg_we, bus_if.chr_we, bus_if.prg_16k,
               bus_if.mirror_v, bus_if.done, bus_if.err, bus_if.sys_hold}, 32'h1);
      check_eq("rst_err_code", 32'(bus_if.err_code), 32'd0);
      check_eq("rst_bus", {1'b0, bus_if.prg_wa, bus_if.chr_wa, 3'b000}, 32'd0);
      check_eq("rst_data", {16'd0, bus_if.prg_wd, bus_if.chr_wd}, 32'd0);
    end
    rst = 1'b0;
    prg_a.delete();
    prg_d.delete();
    chr_a.delete();
    chr_d.delete();
    done_seen = 1'b0;
    err_seen  = 1'b0;
    @(negedge clk);
    if (check_vals) check_eq("ready_after_rst", 32'(bus_if.in_ready), 32'd1);
  endtask

  task automatic run_case(input string name, input logic [7:0] h4, input logic [7:0] h5,
                          input logic [7:0] h6, input logic [7:0] h7, input int bad_idx,
                          input logic [7:0] bad_val);
    int code, total, sent, skip, nprg, nchr, bad;
    build_img(h4, h5, h6, h7, bad_idx, bad_val);
    code  = model_code();
    total = model_consumed(code);
    skip  = (code == 0 && h6[2]) ? 512 : 0;
    nprg  = (code == 0) ? int'(h4) * 16384 : 0;
    nchr  = (code == 0) ? int'(h5) * 8192 : 0;
    send(total + 8, 1'b0, sent);
    repeat (3) @(negedge clk);
    check_eq({name, "_consumed"}, 32'(sent), 32'(total));
    check_eq({name, "_err"}, 32'(bus_if.err), 32'(code != 0));
    check_eq({name, "_err_code"}, 32'(bus_if.err_code), 32'(code));
    check_eq({name, "_done"}, 32'(bus_if.done), 32'(code == 0));
    check_eq({name, "_sys_hold"}, 32'(bus_if.sys_hold), 32'(code != 0));
    check_eq({name, "_in_ready"}, 32'(bus_if.in_ready), 32'd0);
    check_eq({name, "_prg_writes"}, 32'(prg_a.size()), 32'(nprg));
    check_eq({name, "_chr_writes"}, 32'(chr_a.size()), 32'(nchr));
    if (code != 0) begin
      check_eq({name, "_err_timing"}, 32'(err_cyc), 32'(acc_cyc));
    end else begin
      check_eq({name, "_prg_16k"}, 32'(bus_if.prg_16k), 32'(h4 == 8'd1));
      check_eq({name, "_mirror_v"}, 32'(bus_if.mirror_v), 32'(h6[0]));
      bad = 0;
      foreach (prg_a[i]) if (prg_a[i] != 32'(i) || prg_d[i] != 32'(img[16 + skip + i])) bad++;
      check_eq({name, "_prg_image"}, 32'(bad), 32'd0);
      bad = 0;
      foreach (chr_a[i]) if (chr_a[i] != 32'(i) || chr_d[i] != 32'(img[16 + skip + nprg + i])) bad++;
      check_eq({name, "_chr_image"}, 32'(bad), 32'd0);
      if (prg_a.size() == nprg && chr_a.size() == nchr) begin
        check_eq({name, "_last_prg_wa"}, prg_a[nprg - 1], 32'(nprg - 1));
        check_eq({name, "_spot_prg"}, prg_d[32'h3FFC], 32'h07);
        check_eq({name, "_first_chr_wa"}, chr_a[0], 32'd0);
        check_eq({name, "_first_chr_wd"}, chr_d[0], 32'(img[16 + skip + nprg]));
      end
      check_eq({name, "_done_with_last_chr"}, 32'(done_cyc), 32'(chr_last_cyc));
      check_eq({name, "_done_timing"}, 32'(done_cyc), 32'(acc_cyc));
    end
    do_reset(1'b0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got no finish, expected finish within budget");
    $fatal(1, "simulation time budget exhausted");
  end

  initial begin
    int sent, bad, idx, code;
    logic [7:0] h4, h5, h6, h7;
    rst = 1'b1;
    bus_if.in_valid = 1'b0;
    bus_if.in_data  = 8'd0;
    repeat (2) @(negedge clk);
    do_reset(1'b1);

    // throttled PRG stream, then reset mid-load
    build_img(8'h01, 8'h01, 8'h00, 8'h00, -1, 8'h00);
    send(116, 1'b1, sent);
    repeat (2) @(negedge clk);
    check_eq("thr_consumed", 32'(sent), 32'd116);
    check_eq("thr_prg_writes", 32'(prg_a.size()), 32'd100);
    bad = 0;
    foreach (prg_a[i]) if (prg_a[i] != 32'(i) || prg_d[i] != 32'(img[16 + i])) bad++;
    check_eq("thr_prg_image", 32'(bad), 32'd0);
    check_eq("thr_hold", {30'd0, bus_if.sys_hold, bus_if.done}, 32'h2);
    do_reset(1'b1);

    run_case("nrom128", 8'h01, 8'h01, 8'h00, 8'h00, -1, 8'h00);
    run_case("nrom256", 8'h02, 8'h01, 8'h01, 8'h00, -1, 8'h00);
    run_case("bad_magic", 8'h01, 8'h01, 8'h00, 8'h00, 2, 8'h54);
    run_case("mapper1", 8'h01, 8'h01, 8'h10, 8'h00, -1, 8'h00);
    run_case("prg3", 8'h03, 8'h01, 8'h00, 8'h00, -1, 8'h00);
    run_case("prg3_chr0", 8'h03, 8'h00, 8'h00, 8'h00, -1, 8'h00);
    run_case("prg0", 8'h00, 8'h01, 8'h00, 8'h00, -1, 8'h00);
    run_case("chr2", 8'h01, 8'h02, 8'h00, 8'h00, -1, 8'h00);
    run_case("mapper_hi", 8'h02, 8'h01, 8'h00, 8'h20, -1, 8'h00);

    for (int k = 0; k < 4; k++) begin
      idx = int'($urandom_range(0, 3));
      run_case("rnd_magic", 8'h01, 8'h01, 8'h00, 8'h00, idx,
               magic_c[idx] ^ 8'($urandom_range(1, 255)));
    end
    for (int k = 0; k < 4; k++) begin
      h4 = 8'($urandom_range(0, 3));
      h5 = 8'($urandom_range(0, 2));
      h6 = 8'($urandom);
      h7 = 8'($urandom);
      build_img(h4, h5, h6, h7, -1, 8'h00);
      code = model_code();
      if (code == 0) h7 = 8'h10;
      run_case("rnd_hdr", h4, h5, h6, h7, -1, 8'h00);
    end

`ifdef INES_TRAINER_SKIP_EN
    build_img(8'h01, 8'h01, 8'h04, 8'h00, -1, 8'h00);
    send(16 + 512 + 4, 1'b0, sent);
    repeat (2) @(negedge clk);
    check_eq("trainer_consumed", 32'(sent), 32'd532);
    check_eq("trainer_prg_writes", 32'(prg_a.size()), 32'd4);
    if (prg_a.size() == 4) begin
      check_eq("trainer_first_wd", prg_d[0], 32'(img[16 + 512]));
      check_eq("trainer_last_wa", prg_a[3], 32'd3);
    end
    check_eq("trainer_no_err", 32'(bus_if.err), 32'd0);
    do_reset(1'b1);
`else
    run_case("trainer", 8'h01, 8'h01, 8'h04, 8'h00, -1, 8'h00);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
